// File: rtl/rv32im_dmem_bridge.sv
// Bridges the core's single-cycle data-RAM port onto a req/gnt/rvalid bus,
// stalling the core until each access completes, errors, or times out.
module rv32im_dmem_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  core_en_i,
   input  logic [ADDR_W-1:0]     core_addr_i,
   input  logic [DATA_W-1:0]     core_wdata_i,
   input  logic [DATA_W/8-1:0]   core_wmask_i,
   output logic [DATA_W-1:0]     core_rdata_o,
   output logic                  core_stall_o,
   output logic                  err_o,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_W-1:0]     bus_addr_o,
   output logic [DATA_W-1:0]     bus_wdata_o,
   output logic [DATA_W/8-1:0]   bus_wmask_o,
   input  logic                  bus_gnt_i,
   input  logic                  bus_rvalid_i,
   input  logic [DATA_W-1:0]     bus_rdata_i,
   input  logic                  bus_err_i
);

   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t              state, state_next;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MASK_W-1:0]   wmask_q;
   logic                we_q;
   logic [7:0]          count_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;

   logic timeout_hit;
   logic complete_write;
   logic resp_read;
   logic timeout_abort;

   // The final REQ/WAIT cycle is the one whose increment would make the count reach TIMEOUT.
   assign timeout_hit    = (TIMEOUT != 0) && (count_q == 8'(TIMEOUT - 1));
   assign complete_write = (state == REQ) && bus_gnt_i && we_q;
   assign resp_read      = ((state == REQ) && bus_gnt_i && !we_q && bus_rvalid_i) ||
                           ((state == WAIT) && bus_rvalid_i);
   assign timeout_abort  = timeout_hit &&
                           (((state == REQ) && !bus_gnt_i) || ((state == WAIT) && !bus_rvalid_i));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (core_en_i) state_next = REQ;
         REQ: begin
            if (bus_gnt_i) begin
               if (we_q || bus_rvalid_i) state_next = DONE;
               else                      state_next = WAIT;
            end else if (timeout_hit) begin
               state_next = DONE;
            end
         end
         WAIT: if (bus_rvalid_i || timeout_hit) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      core_stall_o = ((state == IDLE) && core_en_i) || (state == REQ) || (state == WAIT);
      bus_req_o    = (state == REQ);
      bus_we_o     = we_q;
      bus_addr_o   = addr_q;
      bus_wdata_o  = wdata_q;
      bus_wmask_o  = wmask_q;
      core_rdata_o = rdata_q;
      err_o        = err_q;
   end

   // Request fields only change when a new access is accepted in IDLE.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         we_q    <= 1'b0;
      end else if ((state == IDLE) && core_en_i) begin
         addr_q  <= core_addr_i;
         wdata_q <= core_wdata_i;
         wmask_q <= core_wmask_i;
         we_q    <= |core_wmask_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if ((state == REQ) || (state == WAIT)) count_q <= count_q + 8'd1;
         else                                   count_q <= '0;

         if (complete_write || timeout_abort) rdata_q <= '0;
         else if (resp_read)                  rdata_q <= bus_err_i ? '0 : bus_rdata_i;

         err_q <= ((complete_write || resp_read) && bus_err_i) || timeout_abort;
      end
   end

endmodule

// File: tb/tb_rv32im_dmem_bridge.sv
// Table-driven bench for rv32im_dmem_bridge: a cycle-scheduled bus responder,
// a scoreboard queue of expected completions, and reset/back-to-back sequences.
module tb_rv32im_dmem_bridge;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rstN;
   logic        coreEn;
   logic [31:0] coreAddr;
   logic [31:0] coreWdata;
   logic [3:0]  coreWmask;
   logic [31:0] coreRdata;
   logic        coreStall;
   logic        errOut;
   logic        busReq;
   logic        busWe;
   logic [31:0] busAddr;
   logic [31:0] busWdata;
   logic [3:0]  busWmask;
   logic        busGnt;
   logic        busRvalid;
   logic [31:0] busRdata;
   logic        busErr;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      int          gntDelay;
      int          rvalidDelay;
      logic [31:0] rdata;
      bit          berr;
      bit          holdEn;
      logic [31:0] expRdata;
      bit          expErr;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   vec_t vecs[9];
   exp_t sbQueue[$];

   rv32im_dmem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk_i        (clk),
      .rst_n_i      (rstN),
      .core_en_i    (coreEn),
      .core_addr_i  (coreAddr),
      .core_wdata_i (coreWdata),
      .core_wmask_i (coreWmask),
      .core_rdata_o (coreRdata),
      .core_stall_o (coreStall),
      .err_o        (errOut),
      .bus_req_o    (busReq),
      .bus_we_o     (busWe),
      .bus_addr_o   (busAddr),
      .bus_wdata_o  (busWdata),
      .bus_wmask_o  (busWmask),
      .bus_gnt_i    (busGnt),
      .bus_rvalid_i (busRvalid),
      .bus_rdata_i  (busRdata),
      .bus_err_i    (busErr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " stall"}, 32'(coreStall), 32'd0);
      checkOutput({tag, " req"},   32'(busReq),    32'd0);
      checkOutput({tag, " err"},   32'(errOut),    32'd0);
      checkOutput({tag, " rdata"}, coreRdata,      32'd0);
      checkOutput({tag, " we"},    32'(busWe),     32'd0);
      checkOutput({tag, " addr"},  busAddr,        32'd0);
      checkOutput({tag, " wdata"}, busWdata,       32'd0);
      checkOutput({tag, " wmask"}, 32'(busWmask),  32'd0);
   endtask

   task automatic idleCycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         coreEn = 1'b0; busGnt = 1'b0; busRvalid = 1'b0; busErr = 1'b0;
         @(negedge clk);
         checkOutput($sformatf("%s idle%0d stall", tag, i), 32'(coreStall), 32'd0);
         checkOutput($sformatf("%s idle%0d req", tag, i),   32'(busReq),    32'd0);
         checkOutput($sformatf("%s idle%0d err", tag, i),   32'(errOut),    32'd0);
      end
   endtask

   // Drives one access and schedules the bus response by cycle number relative to core_en.
   task automatic applyStimulus(input vec_t v, input string tag);
      int   gntCycle, rvCycle, doneCycle, reqLast;
      bit   isWrite;
      exp_t e, got;
      isWrite  = (v.wmask != 4'd0);
      gntCycle = (v.gntDelay < 0) ? -1 : 1 + v.gntDelay;
      if (v.gntDelay < 0) begin
         rvCycle = -1; doneCycle = 1 + TO; reqLast = TO;
      end else if (isWrite) begin
         rvCycle = -1; doneCycle = gntCycle + 1; reqLast = gntCycle;
      end else begin
         rvCycle = gntCycle + v.rvalidDelay; doneCycle = rvCycle + 1; reqLast = gntCycle;
      end
      for (int c = 0; c <= doneCycle; c++) begin
         @(posedge clk); #1;
         coreEn    = (c == 0) || v.holdEn;
         coreAddr  = v.addr;
         coreWdata = v.wdata;
         coreWmask = v.wmask;
         busGnt    = (c == gntCycle);
         busRvalid = (c == rvCycle) || (!isWrite && gntCycle > 1 && c == 1);
         busRdata  = (c == rvCycle) ? v.rdata : (32'hBAD0_0000 | 32'(c));
         busErr    = v.berr && ((isWrite && c == gntCycle) || (!isWrite && c == rvCycle));
         if (c == 0) begin
            e.rdata = v.expRdata;
            e.err   = v.expErr;
            sbQueue.push_back(e);
         end
         @(negedge clk);
         checkOutput($sformatf("%s c%0d stall", tag, c), 32'(coreStall), 32'(c < doneCycle));
         checkOutput($sformatf("%s c%0d req", tag, c), 32'(busReq), 32'(c >= 1 && c <= reqLast));
         if (c >= 1 && c <= reqLast) begin
            checkOutput($sformatf("%s c%0d addr", tag, c),  busAddr,  v.addr);
            checkOutput($sformatf("%s c%0d wdata", tag, c), busWdata, v.wdata);
            checkOutput($sformatf("%s c%0d wmask", tag, c), 32'(busWmask), 32'(v.wmask));
            checkOutput($sformatf("%s c%0d we", tag, c),    32'(busWe), 32'(isWrite));
         end
         if (c == doneCycle) begin
            got = sbQueue.pop_front();
            checkOutput($sformatf("%s done rdata", tag), coreRdata, got.rdata);
            checkOutput($sformatf("%s done err", tag), 32'(errOut), 32'(got.err));
         end else begin
            checkOutput($sformatf("%s c%0d err", tag, c), 32'(errOut), 32'd0);
         end
      end
   endtask

   initial begin
      vec_t rv;
      vecs[0] = '{32'h40,  32'h0,        4'b0000, 0,  2, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{32'h100, 32'h0000ABCD, 4'b0011, 3,  0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
      vecs[2] = '{32'h200, 32'h0,        4'b0000, 0,  0, 32'h12345678, 1'b0, 1'b0, 32'h12345678, 1'b0};
      vecs[3] = '{32'h300, 32'h0,        4'b0000, -1, 0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1};
      vecs[4] = '{32'h44,  32'h0,        4'b0000, 1,  1, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0,        1'b1};
      vecs[5] = '{32'h4C,  32'h0,        4'b0000, 0,  1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0};
      vecs[6] = '{32'h48,  32'h11223344, 4'b1111, 0,  0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1};
      vecs[7] = '{32'h50,  32'h0,        4'b0000, 0,  0, 32'h11112222, 1'b0, 1'b1, 32'h11112222, 1'b0};
      vecs[8] = '{32'h80,  32'h0,        4'b0000, 2,  3, 32'h0BADCAFE, 1'b0, 1'b0, 32'h0BADCAFE, 1'b0};

      rstN = 1'b0; coreEn = 1'b0; coreAddr = '0; coreWdata = '0; coreWmask = '0;
      busGnt = 1'b0; busRvalid = 1'b0; busRdata = '0; busErr = 1'b0;
      #3;
      checkAllZero("reset");
      @(posedge clk); @(posedge clk); #1;
      rstN = 1'b1;
      idleCycles(2, "post-reset");

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i], $sformatf("v%0d", i));
         if (!vecs[i].holdEn) idleCycles(2, $sformatf("v%0d", i));
      end

      // Reset asserted while the read sits in WAIT; a late rvalid must be ignored.
      @(posedge clk); #1;
      coreEn = 1'b1; coreAddr = 32'h500; coreWmask = 4'b0000;
      @(negedge clk);
      checkOutput("rst seq idle stall", 32'(coreStall), 32'd1);
      @(posedge clk); #1;
      coreEn = 1'b0; busGnt = 1'b1;
      @(negedge clk);
      checkOutput("rst seq req", 32'(busReq), 32'd1);
      @(posedge clk); #1;
      busGnt = 1'b0;
      @(negedge clk);
      checkOutput("rst seq wait stall", 32'(coreStall), 32'd1);
      checkOutput("rst seq wait req", 32'(busReq), 32'd0);
      #2;
      rstN = 1'b0;
      #1;
      checkAllZero("rst mid-wait");
      @(posedge clk); #1;
      rstN = 1'b1; busRvalid = 1'b1; busRdata = 32'h77778888;
      @(negedge clk);
      checkOutput("rst stray rvalid stall", 32'(coreStall), 32'd0);
      @(posedge clk); #1;
      busRvalid = 1'b0;
      @(negedge clk);
      checkOutput("rst stray rvalid rdata", coreRdata, 32'd0);
      checkOutput("rst stray rvalid err", 32'(errOut), 32'd0);
      checkOutput("rst stray rvalid req", 32'(busReq), 32'd0);
      rv = '{32'h504, 32'h0, 4'b0000, 0, 1, 32'h600DF00D, 1'b0, 1'b0, 32'h600DF00D, 1'b0};
      applyStimulus(rv, "after-rst");
      idleCycles(2, "after-rst");

      checkOutput("scoreboard empty", 32'(sbQueue.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
